// File: rtl/adder_operand_loader_if.sv
// Signal bundle between the operand loader and the board (switches, button, adder, display).
// The master side is the loader; the slave side is the board and the adder it feeds.
interface adder_operand_loader_if;
  logic [7:0] sw;
  logic       sw_cin;
  logic       btn_load;
  logic [7:0] s_in;
  logic       cout_in;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [8:0] result;
  logic       result_vld;
  logic [1:0] state;

  modport master (
    input  sw, sw_cin, btn_load, s_in, cout_in,
    output a, b, cin, result, result_vld, state
  );

  modport slave (
    output sw, sw_cin, btn_load, s_in, cout_in,
    input  a, b, cin, result, result_vld, state
  );
endinterface

// File: rtl/adder_operand_loader.sv
// Operand stage for the 8-bit ripple adder: a debounced LOAD button steps the
// A / B+Cin capture sequence, and the adder's {Cout,S} is registered for display.
module adder_operand_loader #(
  parameter int unsigned DebounceCycles = 1000000
) (
  input logic                    clk,
  input logic                    rst,
  adder_operand_loader_if.master bus
);

  localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  typedef enum logic [1:0] {
    StLoadA  = 2'b00,
    StLoadB  = 2'b01,
    StSettle = 2'b10,
    StShow   = 2'b11
  } state_e;

  logic [1:0]      sync_q;
  logic            deb_q, deb_d;
  logic            deb_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic [8:0] result_q, result_d;
  logic       vld_q, vld_d;

  // Button path: 2-FF synchroniser, stability counter, rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], bus.btn_load};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoadA;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoadA:  if (press) state_d = StLoadB;
      StLoadB:  if (press) state_d = StSettle;
      StSettle: state_d = StShow;
      StShow:   if (press) state_d = StLoadB;
      default:  state_d = StLoadA;
    endcase
  end

  // FSM outputs: next values of the operand and result registers.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    result_d = result_q;
    vld_d    = vld_q;
    unique case (state_q)
      StLoadA: begin
        if (press) a_d = bus.sw;
      end
      StLoadB: begin
        if (press) begin
          b_d   = bus.sw;
          cin_d = bus.sw_cin;
        end
      end
      StSettle: begin
        // Adder inputs have been stable since the B load, so its outputs are valid here.
        result_d = {bus.cout_in, bus.s_in};
        vld_d    = 1'b1;
      end
      StShow: begin
        if (press) begin
          a_d   = bus.sw;
          vld_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.cin        = cin_q;
  assign bus.result     = result_q;
  assign bus.result_vld = vld_q;
  assign bus.state      = state_q;

endmodule
